// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: on-the-fly key expansion, 1 or 2 rounds per clock.
// Optional build macro AES_ENC_ZEROIZE_EN clears state/round key after each output handshake.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = SBOX[a];
endmodule

// One state column: SubBytes, optional MixColumns, AddRoundKey.
module aes_round_lane (
    input  logic [31:0] col,
    input  logic [31:0] rkw,
    input  logic        last,
    output logic [31:0] col_nxt
);
    logic [31:0] sb;
    logic [31:0] mc;
    logic [7:0]  a0, a1, a2, a3;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar r = 0; r < 4; r++) begin : g_sb
        aes_sbox u_sbox (.a(col[31-8*r -: 8]), .y(sb[31-8*r -: 8]));
    end

    assign {a0, a1, a2, a3} = sb;
    assign mc = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    assign col_nxt = (last ? sb : mc) ^ rkw;
endmodule

// One full round: next round key from the current one, then state update with that key.
module aes_round (
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    input  logic         last,
    output logic [127:0] st_nxt,
    output logic [127:0] rk_nxt
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0][31:0] w, kw, col_sr, col_nxt;
    logic [31:0] rot, sub;

    for (genvar c = 0; c < NUM_LANES; c++) begin : g_words
        assign w[c] = rk[127-32*c -: 32];
    end

    assign rot = {w[3][23:0], w[3][31:24]};
    for (genvar b = 0; b < 4; b++) begin : g_ks
        aes_sbox u_sbox (.a(rot[31-8*b -: 8]), .y(sub[31-8*b -: 8]));
    end

    always_comb begin
        kw[0] = w[0] ^ sub ^ {rcon, 24'h0};
        for (int c = 1; c < NUM_LANES; c++) kw[c] = kw[c-1] ^ w[c];
    end

    // ShiftRows is pure wiring: row r of column c comes from column (c+r)%4.
    for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign col_sr[c][31-8*r -: 8] = st[127-8*(4*((c+r)%4)+r) -: 8];
        end
        aes_round_lane u_lane (
            .col    (col_sr[c]),
            .rkw    (kw[c]),
            .last   (last),
            .col_nxt(col_nxt[c])
        );
        assign st_nxt[127-32*c -: 32] = col_nxt[c];
        assign rk_nxt[127-32*c -: 32] = kw[c];
    end
endmodule

module aes_encrypt_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] PlainText,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] CipherText,
    output logic         busy
);
    localparam int RPC = ROUNDS_PER_CYCLE;

    if (RPC != 1 && RPC != 2) begin : g_bad_rpc
        $error("aes_encrypt_iter: ROUNDS_PER_CYCLE must be 1 or 2");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [127:0] st;
        logic [127:0] rk;
    } rnd_t;

    logic [1:0]   fsm_q;
    logic [127:0] state_q, rk_q;
    logic [3:0]   rnd_q;
    logic         rdy_q;
    logic         rnd_last;
    logic [RPC:0][127:0] st_chain, rk_chain;
    rnd_t         nxt;

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign st_chain[0] = state_q;
    assign rk_chain[0] = rk_q;

    // rnd_q counts completed rounds; stage g computes round rnd_q+g+1.
    for (genvar g = 0; g < RPC; g++) begin : g_rnd
        logic [3:0] rnum;
        logic [7:0] rcon;
        assign rnum = rnd_q + 4'(g + 1);
        assign rcon = rcon_of(rnum);
        aes_round u_round (
            .st    (st_chain[g]),
            .rk    (rk_chain[g]),
            .rcon  (rcon),
            .last  (rnum == 4'd10),
            .st_nxt(st_chain[g+1]),
            .rk_nxt(rk_chain[g+1])
        );
    end

    assign nxt      = '{st: st_chain[RPC], rk: rk_chain[RPC]};
    assign rnd_last = (rnd_q == 4'(10 - RPC));

    // rdy_q keeps in_ready low during reset and until the first edge after release.
    assign in_ready  = rdy_q && (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q != S_IDLE);

`ifdef AES_ENC_ZEROIZE_EN
    assign CipherText = out_valid ? state_q : 128'h0;
`else
    assign CipherText = state_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q <= PlainText ^ key;
                        rk_q    <= key;
                        rnd_q   <= '0;
                        fsm_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    state_q <= nxt.st;
                    rk_q    <= nxt.rk;
                    rnd_q   <= rnd_q + 4'(RPC);
                    if (rnd_last) fsm_q <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        fsm_q <= S_IDLE;
`ifdef AES_ENC_ZEROIZE_EN
                        state_q <= '0;
                        rk_q    <= '0;
`endif
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: one instance per ROUNDS_PER_CYCLE value, FIPS vectors plus random blocks vs a byte-level model.
module tb_aes_encrypt_iter;
    logic clk, rst_n;
    logic         iv [2];
    logic         ord[2];
    logic [127:0] pt [2];
    logic [127:0] ky [2];
    logic         ir [2];
    logic         ov [2];
    logic         bz [2];
    logic [127:0] ct [2];

    int checks, failures;
    logic [7:0] sbx [256];

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;
    vec_t vt[3];

    aes_encrypt_iter #(.ROUNDS_PER_CYCLE(1)) u_enc1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .PlainText(pt[0]), .key(ky[0]), .out_valid(ov[0]), .out_ready(ord[0]),
        .CipherText(ct[0]), .busy(bz[0]));

    aes_encrypt_iter #(.ROUNDS_PER_CYCLE(2)) u_enc2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .PlainText(pt[1]), .key(ky[1]), .out_valid(ov[1]), .out_ready(ord[1]),
        .CipherText(ct[1]), .busy(bz[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Reference AES-128: full key schedule up front, byte-array state.
    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [7:0]  s[16], t[16];
        logic [31:0] w[44];
        logic [31:0] tmp;
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbx[tmp[23:16]], sbx[tmp[15:8]], sbx[tmp[7:0]], sbx[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbx[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept one block on instance d, measure accept-to-out_valid cycles, then handshake.
    task automatic run_blk(input int d, input logic [127:0] p, input logic [127:0] k,
                           output logic [127:0] res, output int lat);
        int n;
        @(negedge clk);
        pt[d] = p; ky[d] = k; iv[d] = 1'b1;
        n = 0;
        while (!ir[d] && n < 50) begin @(negedge clk); n++; end
        if (!ir[d]) chk("accept_timeout", 128'(ir[d]), 128'(1));
        @(posedge clk);
        @(negedge clk);
        iv[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 50) begin @(negedge clk); lat++; end
        if (!ov[d]) chk("out_valid_timeout", 128'(ov[d]), 128'(1));
        res = ct[d];
        ord[d] = 1'b1;
        @(negedge clk);
        ord[d] = 1'b0;
    endtask

    initial begin
        logic [127:0] res, exp, held;
        logic [127:0] q[$];
        int lat, n, last_t, nout;

        checks = 0; failures = 0;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbx[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        vt[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vt[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32};
        vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ord[d] = 1'b0; pt[d] = '0; ky[d] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 128'(ir[d]), 128'(0));
            chk("rst_out_valid", 128'(ov[d]), 128'(0));
            chk("rst_busy", 128'(bz[d]), 128'(0));
            chk("rst_ciphertext", ct[d], 128'h0);
        end
        rst_n = 1'b1;
        #1 chk("in_ready_before_edge", 128'(ir[0]), 128'(0));
        @(negedge clk);
        chk("in_ready_after_edge", 128'(ir[0]), 128'(1));

        // Known-answer vectors on both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                run_blk(d, vt[i].pt, vt[i].key, res, lat);
                chk($sformatf("kat%0d_rpc%0d_ct", i, d + 1), res, vt[i].ct);
                chk($sformatf("kat%0d_rpc%0d_latency", i, d + 1), 128'(lat), 128'(d == 0 ? 10 : 5));
                chk("post_hs_out_valid", 128'(ov[d]), 128'(0));
                chk("post_hs_in_ready", 128'(ir[d]), 128'(1));
`ifdef AES_ENC_ZEROIZE_EN
                chk("zeroize_ct", ct[d], 128'h0);
                if (d == 0) begin
                    chk("zeroize_state", u_enc1.state_q, 128'h0);
                    chk("zeroize_rk", u_enc1.rk_q, 128'h0);
                end else begin
                    chk("zeroize_state", u_enc2.state_q, 128'h0);
                    chk("zeroize_rk", u_enc2.rk_q, 128'h0);
                end
`else
                chk("retain_ct", ct[d], vt[i].ct);
`endif
            end
        end

        // Backpressure: all-zero block held in DONE for 20 cycles
        run_blk(0, 128'h0, 128'h0, res, lat);
        @(negedge clk);
        pt[0] = '0; ky[0] = '0; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 50) begin @(negedge clk); n++; end
        held = ct[0];
        chk("bp_first_ct", held, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(ov[0]), 128'(1));
            chk("bp_ct_stable", ct[0], 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
            chk("bp_in_ready", 128'(ir[0]), 128'(0));
        end
        ord[0] = 1'b1;
        @(negedge clk);
        ord[0] = 1'b0;
        chk("bp_release_in_ready", 128'(ir[0]), 128'(1));
        chk("bp_release_out_valid", 128'(ov[0]), 128'(0));

        // Input disturbance during RUN
        @(negedge clk);
        pt[0] = vt[0].pt; ky[0] = vt[0].key; iv[0] = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        while (!ov[0] && n < 50) begin
            chk("dist_in_ready", 128'(ir[0]), 128'(0));
            pt[0] = rnd128(); ky[0] = rnd128();
            @(negedge clk);
            n++;
        end
        iv[0] = 1'b0;
        chk("dist_ct", ct[0], vt[0].ct);
        ord[0] = 1'b1;
        @(negedge clk);
        ord[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("dist_no_second_accept", 128'(bz[0]), 128'(0));
        end

        // Reset at round 5
        @(negedge clk);
        pt[0] = vt[0].pt; ky[0] = vt[0].key; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid_busy_before_reset", 128'(bz[0]), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(ov[0]), 128'(0));
        chk("mid_rst_busy", 128'(bz[0]), 128'(0));
        chk("mid_rst_ct", ct[0], 128'h0);
        chk("mid_rst_in_ready", 128'(ir[0]), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_blk(0, vt[1].pt, vt[1].key, res, lat);
        chk("after_rst_ct", res, vt[1].ct);
        chk("after_rst_latency", 128'(lat), 128'(10));

        // Random blocks vs model
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++) begin
                logic [127:0] rp, rk;
                rp = rnd128(); rk = rnd128();
                run_blk(d, rp, rk, res, lat);
                chk($sformatf("rand_rpc%0d_ct", d + 1), res, aes_ref(rp, rk));
            end
        end

        // Streaming with out_ready held high: block period and results
        for (int d = 0; d < 2; d++) begin
            q.delete();
            ord[d] = 1'b1;
            pt[d] = rnd128(); ky[d] = rnd128();
            last_t = -1; nout = 0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                iv[d] = (c < 40);
                if (!ir[d]) begin pt[d] = rnd128(); ky[d] = rnd128(); end
                if (ov[d]) begin
                    exp = (q.size() > 0) ? q.pop_front() : 128'hx;
                    chk($sformatf("stream_rpc%0d_ct", d + 1), ct[d], exp);
                    if (last_t >= 0)
                        chk($sformatf("stream_rpc%0d_period", d + 1), 128'(c - last_t), 128'(d == 0 ? 12 : 7));
                    last_t = c; nout++;
                end
                if (ir[d] && iv[d]) q.push_back(aes_ref(pt[d], ky[d]));
            end
            iv[d] = 1'b0; ord[d] = 1'b0;
            chk("stream_drained", 128'(q.size()), 128'(0));
            chk("stream_enough_blocks", 128'(nout >= 3), 128'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 The block SHALL have parameter ROUNDS_PER_CYCLE, default 1, the number of AES rounds computed per clock; legal values are 1 and 2, and any other value is an elaboration error.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit, indicating that PlainText and key are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit, indicating the block can accept a block.
REQ-006 The block SHALL have port PlainText, input, 128 bits, the plaintext block; byte 0 is bits [127:120], loaded column-major as in FIPS-197.
REQ-007 The block SHALL have port key, input, 128 bits, the AES-128 cipher key, using the same byte order as PlainText.
REQ-008 The block SHALL have port out_valid, output, 1 bit, indicating that CipherText is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, indicating that the downstream stage accepts CipherText.
REQ-010 The block SHALL have port CipherText, output, 128 bits, the encrypted block, in the same byte order as PlainText.
REQ-011 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL implement AES-128 encryption per FIPS-197: initial AddRoundKey, rounds 1-9 (SubBytes, ShiftRows, MixColumns, AddRoundKey), and round 10 without MixColumns.
REQ-013 Round keys SHALL be expanded on the fly, one round key per round, with no stored key schedule; Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-016 On in_valid & in_ready, the block SHALL register PlainText^key into the state, register key as round key 0, clear the round counter, and go to RUN.
REQ-017 In RUN, the block SHALL complete ROUNDS_PER_CYCLE rounds per cycle and go to DONE in the same edge that completes round 10.
REQ-018 Latency from the accept edge to out_valid=1 SHALL be exactly 10 cycles for ROUNDS_PER_CYCLE=1 and exactly 5 cycles for ROUNDS_PER_CYCLE=2.
REQ-019 In DONE, out_valid SHALL be 1, and CipherText SHALL hold the result stably until out_valid & out_ready.
REQ-020 On out_valid & out_ready, the FSM SHALL go to IDLE, so out_valid=0 and in_ready=1 on the next cycle; a new accept SHALL NOT occur in the same cycle as an output handshake.
REQ-021 in_valid while in_ready=0 SHALL be ignored, and PlainText/key changes during RUN or DONE SHALL NOT affect the result.
REQ-022 out_ready held permanently at 1 SHALL give one block per 12 cycles (ROUNDS_PER_CYCLE=1) or per 7 cycles (ROUNDS_PER_CYCLE=2).
REQ-023 CipherText SHALL be 0 when out_valid=0, except where REQ-028 states otherwise.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately (asynchronously) force: FSM=IDLE, state, round-key and round-counter registers=0, out_valid=0, CipherText=0, busy=0.
REQ-025 While rst_n=0, in_ready SHALL be 0; it SHALL become 1 on the first rising clk edge after rst_n deasserts.
REQ-026 Reset during RUN or DONE SHALL abandon the block with no output, and the next accepted block SHALL encrypt correctly.

Configuration
REQ-027 With macro AES_ENC_ZEROIZE_EN defined, the state and round-key registers SHALL be cleared to 0 on the output-handshake edge and on entry to IDLE, and CipherText SHALL read 0 whenever out_valid=0.
REQ-028 Without AES_ENC_ZEROIZE_EN, those registers SHALL retain their last values in IDLE, CipherText SHALL be unspecified when out_valid=0, and no zeroizing logic SHALL be synthesized.

Verification
REQ-029 Test FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, PlainText 00112233445566778899aabbccddeeff -> CipherText 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 10 cycles after accept.
REQ-030 Test FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, PlainText 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32, for both ROUNDS_PER_CYCLE=1 and ROUNDS_PER_CYCLE=2 (latency 5 cycles for the latter).
REQ-031 Test backpressure: all-zero key and PlainText with out_ready=0 for 20 cycles -> out_valid stays 1, CipherText stays 66e94bd4ef8a2c3b884cfa59ca342b2e, and in_ready stays 0; then out_ready=1 -> in_ready=1 on the next cycle.
REQ-032 Test input disturbance: accept vector C.1, then drive random PlainText/key with in_valid=1 during RUN -> result still 69c4e0d86a7b0430d8cdb78070b4c55a and no second accept.
REQ-033 Test reset mid-operation: assert rst_n=0 at round 5 -> out_valid, busy and CipherText go 0 immediately; after release, App. B vector -> correct ciphertext.
REQ-034 Test zeroize: with AES_ENC_ZEROIZE_EN, after the output handshake, the internal state and round key read 0 and CipherText=0; without the macro, CipherText retains its last value.
